// File: rtl/tx_e1_demux.sv
// Transmit E1 tributary demux: slots the 3-lane {Dv,Dat} stream into per-channel
// elastic buffers and regenerates gapped E1 data/clock pairs. Sticky flags: TX_E1_STAT_EN.
module tx_e1_demux #(
  parameter int D_W    = 42,
  parameter int BUF_AW = 3
) (
  input  logic           Ck,
  input  logic           Rs,
  input  logic [3:0]     E1_MFI,
  input  logic [5:0]     Dv_Dat,
  input  logic           Err_Clr,
  output logic [D_W-1:0] E1_Out_Dat,
  output logic [D_W-1:0] E1_Out_Ck,
  output logic [D_W-1:0] E1_Ovf,
  output logic [D_W-1:0] E1_Udf
);

  localparam int DEPTH = 2 ** BUF_AW;
  localparam int HALF  = DEPTH / 2;
  localparam int HI    = DEPTH - 2;
  localparam int LO    = 2;
  localparam logic [BUF_AW:0] FULL_LVL = DEPTH[BUF_AW:0];
  localparam logic [BUF_AW:0] HALF_LVL = HALF[BUF_AW:0];
  localparam logic [BUF_AW:0] HI_LVL   = HI[BUF_AW:0];
  localparam logic [BUF_AW:0] LO_LVL   = LO[BUF_AW:0];

  typedef enum logic {IDLE, RUN} state_t;

  logic [3:0] mfi_q;
  logic [5:0] dv_dat_q;

  always_ff @(posedge Ck or negedge Rs) begin
    if (!Rs) begin
      mfi_q    <= '0;
      dv_dat_q <= '0;
    end else begin
      mfi_q    <= E1_MFI;
      dv_dat_q <= Dv_Dat;
    end
  end

`ifndef TX_E1_STAT_EN
  logic unused_err_clr;
  assign unused_err_clr = Err_Clr;
`endif

  for (genvar j = 0; j < D_W; j++) begin : g_ch
    localparam int LANE = j / 14;
    localparam int SLOT = j % 14;

    logic              wr_en, wr_dat, full, wr_ok;
    logic [BUF_AW-1:0] wp, rp;
    logic [BUF_AW:0]   fill;
    logic              mem [DEPTH];
    state_t            state, nxt_state;
    logic [5:0]        cnt, nxt_cnt, per, nxt_per;
    logic              pop, udf_set, ck_rise, ck_fall;
    logic              dat_q, ck_q;

    assign wr_en  = dv_dat_q[2*LANE+1] && (mfi_q == SLOT[3:0]);
    assign wr_dat = dv_dat_q[2*LANE];
    // A full buffer drops the incoming bit even if a pop happens on the same edge.
    assign full   = (fill == FULL_LVL);
    assign wr_ok  = wr_en && !full;

    always_ff @(posedge Ck) begin
      if (wr_ok) mem[wp] <= wr_dat;
    end

    always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt;
      nxt_per   = per;
      pop       = 1'b0;
      udf_set   = 1'b0;
      ck_rise   = 1'b0;
      ck_fall   = 1'b0;
      case (state)
        IDLE: begin
          if (fill >= HALF_LVL) begin
            nxt_state = RUN;
            nxt_cnt   = '0;
          end
        end
        RUN: begin
          if (cnt == 6'd0) begin
            ck_fall = 1'b1;
            if (fill == '0) begin
              udf_set   = 1'b1;
              nxt_state = IDLE;
            end else begin
              // Period trims the line rate to steer the fill back toward half.
              pop     = 1'b1;
              nxt_cnt = 6'd1;
              if (fill >= HI_LVL)      nxt_per = 6'd37;
              else if (fill <= LO_LVL) nxt_per = 6'd39;
              else                     nxt_per = 6'd38;
            end
          end else begin
            if (cnt == per - 6'd1) nxt_cnt = '0;
            else                   nxt_cnt = cnt + 6'd1;
            if (cnt == {1'b0, per[5:1]}) ck_rise = 1'b1;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end

    always_ff @(posedge Ck or negedge Rs) begin
      if (!Rs) begin
        state <= IDLE;
        cnt   <= '0;
        per   <= 6'd38;
        wp    <= '0;
        rp    <= '0;
        fill  <= '0;
        dat_q <= 1'b0;
        ck_q  <= 1'b0;
      end else begin
        state <= nxt_state;
        cnt   <= nxt_cnt;
        per   <= nxt_per;
        if (wr_ok) wp <= wp + 1'b1;
        if (pop) begin
          rp    <= rp + 1'b1;
          dat_q <= mem[rp];
        end
        if (ck_fall)      ck_q <= 1'b0;
        else if (ck_rise) ck_q <= 1'b1;
        case ({wr_ok, pop})
          2'b10:   fill <= fill + 1'b1;
          2'b01:   fill <= fill - 1'b1;
          default: fill <= fill;
        endcase
      end
    end

    assign E1_Out_Dat[j] = dat_q;
    assign E1_Out_Ck[j]  = ck_q;

`ifdef TX_E1_STAT_EN
    logic ovf_q, udf_q;

    // A new error on the same edge as Err_Clr keeps the flag set.
    always_ff @(posedge Ck or negedge Rs) begin
      if (!Rs) begin
        ovf_q <= 1'b0;
        udf_q <= 1'b0;
      end else begin
        if (wr_en && full) ovf_q <= 1'b1;
        else if (Err_Clr)  ovf_q <= 1'b0;
        if (udf_set)       udf_q <= 1'b1;
        else if (Err_Clr)  udf_q <= 1'b0;
      end
    end

    assign E1_Ovf[j] = ovf_q;
    assign E1_Udf[j] = udf_q;
`else
    logic unused_flags;
    assign unused_flags = udf_set;
    assign E1_Ovf[j]    = 1'b0;
    assign E1_Udf[j]    = 1'b0;
`endif
  end

endmodule
